gp_arbiter: RTL and testbench



---
 rtl/gp_arbiter_if.sv | 35 +++
 rtl/gp_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_gp_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gp_arbiter_if.sv
// Requester and graphics-processor bus around gp_arbiter; master is the
// environment side (requesters + processor), slave is the arbiter.
interface gp_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  opcode_in;
    logic [29:0] tl_x_in;
    logic [29:0] br_x_in;
    logic [26:0] tl_y_in;
    logic [26:0] br_y_in;
    logic [35:0] arg_in;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        err;
    logic        busy;
    logic        gp_en;
    logic        gp_opcode;
    logic [9:0]  gp_tl_x;
    logic [9:0]  gp_br_x;
    logic [8:0]  gp_tl_y;
    logic [8:0]  gp_br_y;
    logic [11:0] gp_arg;
    logic        gp_finish;

    modport master (
        output req, opcode_in, tl_x_in, br_x_in, tl_y_in, br_y_in, arg_in, gp_finish,
        input  gnt, done, err, busy, gp_en, gp_opcode,
               gp_tl_x, gp_br_x, gp_tl_y, gp_br_y, gp_arg
    );

    modport slave (
        input  req, opcode_in, tl_x_in, br_x_in, tl_y_in, br_y_in, arg_in, gp_finish,
        output gnt, done, err, busy, gp_en, gp_opcode,
               gp_tl_x, gp_br_x, gp_tl_y, gp_br_y, gp_arg
    );
endinterface

// File: rtl/gp_arbiter.sv
// Shares the rectangle-fill graphics processor among three requesters: picks a winner,
// latches and clips its command to the screen, and runs the gp_en/gp_finish handshake.
module gp_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned TIMEOUT    = 1_048_575,
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480
) (
    input logic         clk,
    input logic         rst_n,
    gp_arbiter_if.slave bus
);
    localparam int unsigned NREQ = 3;
    localparam int unsigned XW   = 10;
    localparam int unsigned YW   = 9;
    localparam int unsigned AW   = 12;
    localparam int unsigned CW   = 20;

    localparam logic [XW-1:0] X_MAX    = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(SCREEN_H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RELEASE
    } state_t;

    typedef struct packed {
        logic          opcode;
        logic [XW-1:0] tl_x;
        logic [XW-1:0] br_x;
        logic [YW-1:0] tl_y;
        logic [YW-1:0] br_y;
        logic [AW-1:0] arg;
    } cmd_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    cmd_t            cmd_q, cmd_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;

    logic [1:0]      base, idx, win;
    logic            win_vld;
    logic [NREQ-1:0] win_oh, owner_oh;
    cmd_t            raw, cand;
    logic            reject;

    // Search order starts one past the last grant; fixed priority always starts at requester 0.
    always_comb begin
        base    = FIXED_PRIO ? 2'd2 : ptr_q;
        idx     = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = 2'((32'(base) + k) % NREQ);
            if (!win_vld && bus.req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign win_oh   = NREQ'(1) << win;
    assign owner_oh = NREQ'(1) << owner_q;

    // Winner's command, bottom-right corner clamped to the screen, then range-checked.
    always_comb begin
        raw = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == 2'(i)) begin
                raw.opcode = bus.opcode_in[i];
                raw.tl_x   = bus.tl_x_in[XW*i +: XW];
                raw.br_x   = bus.br_x_in[XW*i +: XW];
                raw.tl_y   = bus.tl_y_in[YW*i +: YW];
                raw.br_y   = bus.br_y_in[YW*i +: YW];
                raw.arg    = bus.arg_in[AW*i +: AW];
            end
        end
        cand = raw;
        if (raw.br_x > X_MAX) cand.br_x = X_MAX;
        if (raw.br_y > Y_MAX) cand.br_y = Y_MAX;
        reject = (cand.tl_x > cand.br_x) || (cand.tl_y > cand.br_y) ||
                 (32'(raw.tl_x) >= SCREEN_W) || (32'(raw.tl_y) >= SCREEN_H);
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = err_q;
        en_d    = en_q;
        case (state_q)
            ST_IDLE: begin
                // A late gp_finish from an aborted job must clear before the next grant.
                if (win_vld && !bus.gp_finish) begin
                    ptr_d   = win;
                    owner_d = win;
                    gnt_d   = win_oh;
                    if (reject) begin
                        done_d = win_oh;
                        err_d  = 1'b1;
                    end else begin
                        cmd_d   = cand;
                        en_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.gp_finish) begin
                    en_d    = 1'b0;
                    done_d  = owner_oh;
                    err_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    en_d    = 1'b0;
                    done_d  = owner_oh;
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!bus.gp_finish) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd2;
            owner_q <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.gp_en     = en_q;
    assign bus.gp_opcode = cmd_q.opcode;
    assign bus.gp_tl_x   = cmd_q.tl_x;
    assign bus.gp_br_x   = cmd_q.br_x;
    assign bus.gp_tl_y   = cmd_q.tl_y;
    assign bus.gp_br_y   = cmd_q.br_y;
    assign bus.gp_arg    = cmd_q.arg;
endmodule

// File: tb/tb_gp_arbiter.sv
// Self-checking bench for gp_arbiter: vector table plus hand sequences, with a
// grant/done scoreboard and a small graphics-processor responder.
module tb_gp_arbiter;
    logic clk;
    logic rst_n;

    gp_arbiter_if bus();
    gp_arbiter_if bus_fp();

    gp_arbiter #(.FIXED_PRIO(1'b0), .TIMEOUT(16), .SCREEN_W(640), .SCREEN_H(480)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    gp_arbiter #(.FIXED_PRIO(1'b1), .TIMEOUT(16), .SCREEN_W(640), .SCREEN_H(480)) u_dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic       op;
        logic [9:0] tlx, brx;
        logic [8:0] tly, bry;
        logic [11:0] arg;
        int         dly;
        logic       e_rej, e_err;
        logic [9:0] e_brx;
        logic [8:0] e_bry;
        int         e_en;
    } vec_t;

    typedef struct {
        int          id;
        logic        rej;
        logic        err;
        logic [50:0] fields;
        int          en;
    } exp_t;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    int   fin_delay = 0;
    logic fin_model = 1'b0;
    logic gp_force  = 1'b0;
    logic fin_fp    = 1'b0;
    int   fin_cnt = 0;
    int   fp_cnt = 0;
    int   en_cnt = 0;

    assign bus.gp_finish    = fin_model | gp_force;
    assign bus_fp.gp_finish = fin_fp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int id, input logic rej, input logic err, input logic op,
                                    input logic [9:0] tlx, input logic [8:0] tly,
                                    input logic [9:0] brx, input logic [8:0] bry,
                                    input logic [11:0] arg, input int en);
        exp_t e;
        e.id = id; e.rej = rej; e.err = err; e.en = en;
        e.fields = {op, tlx, brx, tly, bry, arg};
        return e;
    endfunction

    function automatic vec_t mk_vec(input int id, input logic op,
                                    input logic [9:0] tlx, input logic [8:0] tly,
                                    input logic [9:0] brx, input logic [8:0] bry,
                                    input logic [11:0] arg, input int dly,
                                    input logic e_rej, input logic e_err,
                                    input logic [9:0] e_brx, input logic [8:0] e_bry, input int e_en);
        vec_t v;
        v.id = id; v.op = op; v.tlx = tlx; v.tly = tly; v.brx = brx; v.bry = bry;
        v.arg = arg; v.dly = dly; v.e_rej = e_rej; v.e_err = e_err;
        v.e_brx = e_brx; v.e_bry = e_bry; v.e_en = e_en;
        return v;
    endfunction

    task automatic drive_cmd(input int id, input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                             input logic [9:0] brx, input logic [8:0] bry, input logic [11:0] arg);
        bus.opcode_in[id]         = op;
        bus.tl_x_in[10*id +: 10]  = tlx;
        bus.tl_y_in[9*id +: 9]    = tly;
        bus.br_x_in[10*id +: 10]  = brx;
        bus.br_y_in[9*id +: 9]    = bry;
        bus.arg_in[12*id +: 12]   = arg;
    endtask

    task automatic scramble();
        bus.opcode_in = 3'($urandom());
        bus.tl_x_in   = 30'($urandom());
        bus.br_x_in   = 30'($urandom());
        bus.tl_y_in   = 27'($urandom());
        bus.br_y_in   = 27'($urandom());
        bus.arg_in    = 36'({$urandom(), $urandom()});
    endtask

    task automatic wait_gnt(input string name, output logic [2:0] g);
        g = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.gnt != 3'b000) begin
                g = bus.gnt;
                return;
            end
        end
        n_vec++; n_bad++;
        $display("FAIL %s: no grant within 40 cycles", name);
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 100; c++) begin
            if (!bus.busy) return;
            @(posedge clk); #1;
        end
        n_vec++; n_bad++;
        $display("FAIL %s: busy still high after 100 cycles", name);
    endtask

    // Processor model: raises gp_finish dly+1 cycles into a job (0 = never), drops it after gp_en falls.
    always @(negedge clk) begin
        if (!rst_n) begin
            fin_model <= 1'b0;
            fin_cnt = 0;
        end else if (bus.gp_en) begin
            fin_cnt++;
            if (fin_delay != 0 && fin_cnt > fin_delay) fin_model <= 1'b1;
        end else begin
            fin_cnt = 0;
            fin_model <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            fin_fp <= 1'b0;
            fp_cnt = 0;
        end else if (bus_fp.gp_en) begin
            fp_cnt++;
            if (fp_cnt > 3) fin_fp <= 1'b1;
        end else begin
            fp_cnt = 0;
            fin_fp <= 1'b0;
        end
    end

    // Scoreboard: grants checked against the queue head, done pops it.
    always @(negedge clk) begin
        exp_t cur;
        if (!rst_n) begin
            sb_q.delete();
            en_cnt = 0;
        end else begin
            if (bus.gnt != 3'b000) begin
                en_cnt = 0;
                if (sb_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL sb_gnt: unexpected gnt=%b", bus.gnt);
                end else begin
                    cur = sb_q[0];
                    check("gnt_onehot", 64'(bus.gnt), 64'(3'b001 << cur.id));
                    check("gnt_en", 64'(bus.gp_en), 64'(!cur.rej));
                    check("gnt_busy", 64'(bus.busy), 64'(!cur.rej));
                    check("gnt_done", 64'(bus.done != 3'b000), 64'(cur.rej));
                    if (!cur.rej)
                        check("gp_bus", 64'({bus.gp_opcode, bus.gp_tl_x, bus.gp_br_x,
                                             bus.gp_tl_y, bus.gp_br_y, bus.gp_arg}), 64'(cur.fields));
                end
            end
            if (bus.gp_en) en_cnt++;
            if (bus.done != 3'b000) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL sb_done: unexpected done=%b", bus.done);
                end else begin
                    cur = sb_q.pop_front();
                    check("done_onehot", 64'(bus.done), 64'(3'b001 << cur.id));
                    check("done_err", 64'(bus.err), 64'(cur.err));
                    check("gp_en_cycles", 64'(en_cnt), 64'(cur.en));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt[7];
        logic [2:0] g;
        int         rr_id[4] = '{0, 1, 2, 0};

        vt[0] = mk_vec(0, 1'b1,   0,   0,  350, 479, 12'h000, 5, 1'b0, 1'b0, 350, 479, 6);
        vt[1] = mk_vec(1, 1'b0, 351,   0,  900, 500, 12'hABC, 2, 1'b0, 1'b0, 639, 479, 3);
        vt[2] = mk_vec(2, 1'b1, 700,  10,  800,  20, 12'h5A5, 0, 1'b1, 1'b1,   0,   0, 0);
        vt[3] = mk_vec(0, 1'b1, 100,  50,   50,  60, 12'h0F0, 0, 1'b1, 1'b1,   0,   0, 0);
        vt[4] = mk_vec(1, 1'b1,  10, 480,   20, 490, 12'h00F, 0, 1'b1, 1'b1,   0,   0, 0);
        vt[5] = mk_vec(2, 1'b0, 639, 479, 1023, 511, 12'hFFF, 1, 1'b0, 1'b0, 639, 479, 2);
        vt[6] = mk_vec(0, 1'b1,   5,   5,    5,   5, 12'h123, 0, 1'b0, 1'b1,   5,   5, 16);

        rst_n = 1'b0;
        bus.req = '0; bus.opcode_in = '0; bus.tl_x_in = '0; bus.br_x_in = '0;
        bus.tl_y_in = '0; bus.br_y_in = '0; bus.arg_in = '0;
        bus_fp.req = '0; bus_fp.opcode_in = '0; bus_fp.tl_x_in = '0; bus_fp.br_x_in = '0;
        bus_fp.tl_y_in = '0; bus_fp.br_y_in = '0; bus_fp.arg_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", 64'({bus.gnt, bus.done, bus.err, bus.busy, bus.gp_en, bus.gp_opcode}), 64'(0));
        check("rst_bus", 64'({bus.gp_tl_x, bus.gp_br_x, bus.gp_tl_y, bus.gp_br_y, bus.gp_arg}), 64'(0));
        check("rst_fp_ctrl", 64'({bus_fp.gnt, bus_fp.done, bus_fp.busy, bus_fp.gp_en}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-requester vectors: in-range, clipped, rejected and timed-out commands.
        foreach (vt[i]) begin
            fin_delay = vt[i].dly;
            drive_cmd(vt[i].id, vt[i].op, vt[i].tlx, vt[i].tly, vt[i].brx, vt[i].bry, vt[i].arg);
            sb_q.push_back(mk_exp(vt[i].id, vt[i].e_rej, vt[i].e_err, vt[i].op, vt[i].tlx, vt[i].tly,
                                  vt[i].e_brx, vt[i].e_bry, vt[i].arg, vt[i].e_en));
            bus.req = 3'(1 << vt[i].id);
            wait_gnt("vec_gnt", g);
            bus.req = '0;
            scramble();
            wait_idle("vec_idle");
            @(posedge clk); #1;
        end

        // After the timeout: err holds, and no grant while a late gp_finish is high.
        check("err_hold", 64'(bus.err), 64'(1));
        gp_force = 1'b1;
        fin_delay = 2;
        drive_cmd(2, 1'b0, 20, 30, 40, 50, 12'h777);
        sb_q.push_back(mk_exp(2, 1'b0, 1'b0, 1'b0, 20, 30, 40, 50, 12'h777, 3));
        bus.req = 3'b100;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_gnt_fin_high", 64'(bus.gnt), 64'(0));
        end
        check("err_hold2", 64'(bus.err), 64'(1));
        gp_force = 1'b0;
        @(posedge clk); #1;
        check("gnt_after_fin_low", 64'(bus.gnt), 64'(3'b100));
        bus.req = '0;
        wait_idle("late_fin_idle");
        @(posedge clk); #1;

        // Round-robin with all three requesting.
        fin_delay = 3;
        drive_cmd(0, 1'b1, 1, 2, 30, 40, 12'h111);
        drive_cmd(1, 1'b0, 3, 4, 640, 100, 12'h222);
        drive_cmd(2, 1'b1, 5, 6, 50, 479, 12'h333);
        sb_q.push_back(mk_exp(0, 1'b0, 1'b0, 1'b1, 1, 2, 30, 40, 12'h111, 4));
        sb_q.push_back(mk_exp(1, 1'b0, 1'b0, 1'b0, 3, 4, 639, 100, 12'h222, 4));
        sb_q.push_back(mk_exp(2, 1'b0, 1'b0, 1'b1, 5, 6, 50, 479, 12'h333, 4));
        sb_q.push_back(mk_exp(0, 1'b0, 1'b0, 1'b1, 1, 2, 30, 40, 12'h111, 4));
        bus.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_gnt("rr_gnt", g);
            check("rr_order", 64'(g), 64'(3'b001 << rr_id[k]));
        end
        bus.req = '0;
        wait_idle("rr_idle");
        @(posedge clk); #1;

        // Reset in the middle of a job, then the pointer restarts from requester 0.
        fin_delay = 30;
        drive_cmd(0, 1'b1, 0, 0, 100, 100, 12'h321);
        sb_q.push_back(mk_exp(0, 1'b0, 1'b0, 1'b1, 0, 0, 100, 100, 12'h321, 31));
        bus.req = 3'b001;
        wait_gnt("mid_gnt", g);
        bus.req = '0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_en", 64'(bus.gp_en), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_async_en", 64'(bus.gp_en), 64'(0));
        check("rst_async_busy", 64'(bus.busy), 64'(0));
        check("rst_async_pulses", 64'({bus.gnt, bus.done, bus.err}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fin_delay = 1;
        drive_cmd(1, 1'b0, 1, 1, 2, 2, 12'h010);
        sb_q.push_back(mk_exp(1, 1'b0, 1'b0, 1'b0, 1, 1, 2, 2, 12'h010, 2));
        bus.req = 3'b010;
        wait_gnt("post_rst_gnt", g);
        check("post_rst_first", 64'(g), 64'(3'b010));
        bus.req = '0;
        wait_idle("post_rst_idle");
        @(posedge clk); #1;
        drive_cmd(0, 1'b1, 7, 7, 9, 9, 12'hA00);
        drive_cmd(2, 1'b0, 8, 8, 9, 9, 12'hA02);
        sb_q.push_back(mk_exp(2, 1'b0, 1'b0, 1'b0, 8, 8, 9, 9, 12'hA02, 2));
        sb_q.push_back(mk_exp(0, 1'b0, 1'b0, 1'b1, 7, 7, 9, 9, 12'hA00, 2));
        bus.req = 3'b111;
        wait_gnt("ptr_gnt", g);
        check("ptr_next_2", 64'(g), 64'(3'b100));
        wait_gnt("ptr_gnt", g);
        check("ptr_next_0", 64'(g), 64'(3'b001));
        bus.req = '0;
        wait_idle("ptr_idle");

        // Fixed priority: requester 0 wins every time while all three request.
        bus_fp.br_x_in = {3{10'd10}};
        bus_fp.br_y_in = {3{9'd10}};
        bus_fp.req = 3'b111;
        for (int k = 0; k < 3; k++) begin
            g = '0;
            for (int c = 0; c < 40 && g == 3'b000; c++) begin
                @(posedge clk); #1;
                g = bus_fp.gnt;
            end
            check("fp_order", 64'(g), 64'(3'b001));
        end
        bus_fp.req = '0;
        for (int c = 0; c < 40 && bus_fp.busy; c++) begin
            @(posedge clk); #1;
        end
        check("fp_idle", 64'(bus_fp.busy), 64'(0));

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
